// File: rtl/stv_coin_pulse.sv
// COIN1 conditioner for the ST-V I/O port block: debounces the raw coin button,
// queues accepted presses and replays each one as a fixed-width low pulse plus a gap.
module stv_coin_pulse #(
    parameter logic [15:0] TICK_DIV    = 16'd1000,
    parameter logic [7:0]  DEB_TICKS   = 8'd5,
    parameter logic [7:0]  PULSE_TICKS = 8'd6,
    parameter logic [7:0]  GAP_TICKS   = 8'd10,
    parameter int          QDEPTH_W    = 3
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                CE_R,
    input  logic                RES_N,
    input  logic                COIN_IN_N,
    input  logic                LOCKOUT,
    output logic                COIN1,
    output logic                BUSY,
    output logic [QDEPTH_W-1:0] PENDING
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [QDEPTH_W-1:0] PEND_MAX = '1;
    localparam logic [QDEPTH_W-1:0] PEND_ONE = QDEPTH_W'(1);

    state_t      state;
    logic [15:0] presc;
    logic [7:0]  deb_cnt;
    logic [7:0]  timer;
    logic        sync1;
    logic        sync2;
    logic        deb_level;
    logic        tick;
    logic        deb_done;
    logic        accept;
    logic        push;
    logic        pop;

    // Handshake: accept is a one-cycle strobe with no back-pressure; the queue
    // absorbs it in the same cycle, or drops it when locked out or full.
    assign tick     = CE_R && (presc == (TICK_DIV - 16'd1));
    assign deb_done = tick && (sync2 != deb_level) && (deb_cnt == (DEB_TICKS - 8'd1));
    assign accept   = deb_done && deb_level;
    assign push     = accept && !LOCKOUT;
    assign pop      = (state == IDLE) && (PENDING != '0);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            presc     <= '0;
            deb_cnt   <= '0;
            deb_level <= 1'b1;
        end else if (!RES_N) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            presc     <= '0;
            deb_cnt   <= '0;
            deb_level <= 1'b1;
        end else begin
            sync1 <= COIN_IN_N;
            sync2 <= sync1;
            if (CE_R) begin
                presc <= tick ? 16'd0 : presc + 16'd1;
            end
            // Any return to the accepted level restarts the hold window.
            if (sync2 == deb_level) begin
                deb_cnt <= '0;
            end else if (deb_done) begin
                deb_level <= sync2;
                deb_cnt   <= '0;
            end else if (tick) begin
                deb_cnt <= deb_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            timer   <= '0;
            PENDING <= '0;
            COIN1   <= 1'b1;
            BUSY    <= 1'b0;
        end else if (!RES_N) begin
            state   <= IDLE;
            timer   <= '0;
            PENDING <= '0;
            COIN1   <= 1'b1;
            BUSY    <= 1'b0;
        end else begin
            COIN1 <= (state != PULSE);
            BUSY  <= (state != IDLE) || (PENDING != '0);
            case ({push, pop})
                2'b10: if (PENDING != PEND_MAX) PENDING <= PENDING + PEND_ONE;
                2'b01: PENDING <= PENDING - PEND_ONE;
                default: ;
            endcase
            case (state)
                IDLE: begin
                    if (pop) begin
                        state <= PULSE;
                        timer <= '0;
                    end
                end
                PULSE: begin
                    if (tick) begin
                        if (timer == (PULSE_TICKS - 8'd1)) begin
                            state <= GAP;
                            timer <= '0;
                        end else begin
                            timer <= timer + 8'd1;
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (timer == (GAP_TICKS - 8'd1)) begin
                            state <= IDLE;
                            timer <= '0;
                        end else begin
                            timer <= timer + 8'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    timer <= '0;
                end
            endcase
        end
    end

    // Zero-length pulse or gap would wrap the timer compare to 255 ticks.
    a_legal_ticks: assert property (@(posedge CLK) (PULSE_TICKS != 8'd0) && (GAP_TICKS != 8'd0));

endmodule
